// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Fetch-stage program counter and instruction-memory fetch sequencer.
//   The next PC comes from one of four sources: sequential PC+4, a taken
//   branch, a J/JAL jump, or a register jump. A redirect that arrives while a
//   fetch is outstanding is buffered, and the instruction returned by that
//   fetch is squashed because it belongs to the wrong path.
//
// Parameters
//   RESET_VECTOR   PC loaded on reset (word aligned)
//
// Ports
//   clk            in   1   rising-edge clock
//   rst_n          in   1   asynchronous reset, active low
//   stall          in   1   pipeline stall; no new fetch issued while high
//   jr             in   1   register-jump redirect strobe
//   jr_addr        in   32  register-jump target (bits [1:0] ignored)
//   jump           in   1   J/JAL redirect strobe
//   jump_target    in   26  instr[25:0]
//   branch_taken   in   1   taken-branch redirect strobe
//   branch_offset  in   16  signed word offset, instr[15:0]
//   imem_req       out  1   fetch request
//   imem_addr      out  32  fetch address, stable until acknowledged
//   imem_ack       in   1   fetch complete
//   fetch_valid    out  1   one-cycle pulse: fetched instruction is live
//   fetch_pc       out  32  address of the instruction flagged by fetch_valid
//   pc             out  32  current PC register
//   pc_plus4       out  32  pc + 4 (combinational, wraps mod 2^32)
// -----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [31:0] r_pc,          w_pc_nxt;
    logic        r_pend_valid,  w_pend_valid_nxt;
    logic [31:0] r_pend_addr,   w_pend_addr_nxt;
    logic        r_fetch_valid, w_fetch_valid_nxt;
    logic [31:0] r_fetch_pc,    w_fetch_pc_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_jr_target;
    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic [31:0] w_target;
    logic        w_redir;

    // ------------------------------------------------------------------
    // Redirect target formation
    // ------------------------------------------------------------------
    assign w_pc_plus4      = r_pc + 32'd4;
    // Masking rather than slicing keeps every jr_addr bit in use.
    assign w_jr_target     = jr_addr & 32'hFFFF_FFFC;
    assign w_jump_target   = {w_pc_plus4[31:28], jump_target, 2'b00};
    assign w_branch_target = w_pc_plus4 + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    assign w_redir = jr | jump | branch_taken;

    // Priority jr > jump > branch; the value is only consumed when w_redir=1.
    always_comb begin
        if (jr)
            w_target = w_jr_target;
        else if (jump)
            w_target = w_jump_target;
        else
            w_target = w_branch_target;
    end

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_addr_nxt   = r_pend_addr;
        w_fetch_valid_nxt = 1'b0;
        w_fetch_pc_nxt    = r_fetch_pc;

        case (r_state)
            BOOT: begin
                // Stall is ignored here: the first fetch always starts.
                w_state_nxt = FETCH;
                if (w_redir)
                    w_pc_nxt = w_target;
            end

            FETCH: begin
                if (imem_ack) begin
                    if (!w_redir && !r_pend_valid) begin
                        w_fetch_valid_nxt = 1'b1;
                        w_fetch_pc_nxt    = r_pc;
                        w_pc_nxt          = w_pc_plus4;
                    end else begin
                        // Wrong-path instruction: squash and steer to the
                        // freshest redirect.
                        w_pc_nxt = w_redir ? w_target : r_pend_addr;
                    end
                    w_pend_valid_nxt = 1'b0;
                    w_state_nxt      = stall ? HOLD : FETCH;
                end else if (w_redir) begin
                    // Request in flight: the address must stay put, so the
                    // redirect is parked until the ack arrives.
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = w_target;
                end
            end

            HOLD: begin
                if (w_redir)
                    w_pc_nxt = w_target;
                if (!stall)
                    w_state_nxt = FETCH;
            end

            default: begin
                w_state_nxt = BOOT;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_VECTOR;
            r_pend_valid  <= 1'b0;
            r_pend_addr   <= 32'd0;
            r_fetch_valid <= 1'b0;
            r_fetch_pc    <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_addr   <= w_pend_addr_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_fetch_pc    <= w_fetch_pc_nxt;
        end
    end

    // Request is decoded from state so an async reset drops it immediately.
    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign fetch_valid = r_fetch_valid;
    assign fetch_pc    = r_fetch_pc;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer. Clean acks push the expected fetch_pc
//   onto a scoreboard queue; each cycle the fetch_valid pulse is popped and
//   compared. Redirect, squash, stall/HOLD, wrap-around and async reset are
//   exercised with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jr;
    logic [31:0] jr_addr;
    logic        jump;
    logic [25:0] jump_target;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int total = 0;
    int bad   = 0;
    logic [31:0] sb[$];

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .jr           (jr),
        .jr_addr      (jr_addr),
        .jump         (jump),
        .jump_target  (jump_target),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .fetch_valid  (fetch_valid),
        .fetch_pc     (fetch_pc),
        .pc           (pc),
        .pc_plus4     (pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge; score any
    // fetch_valid pulse against the queue.
    task automatic tick();
        logic [31:0] exp_pc;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            exp_pc = sb.pop_front();
            check("fetch_valid", {31'd0, fetch_valid}, 32'd1);
            check("fetch_pc", fetch_pc, exp_pc);
        end else begin
            check("fetch_valid_idle", {31'd0, fetch_valid}, 32'd0);
        end
    endtask

    task automatic clear_strobes();
        jr           = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        jr            = 1'b0;
        jr_addr       = 32'd0;
        jump          = 1'b0;
        jump_target   = 26'd0;
        branch_taken  = 1'b0;
        branch_offset = 16'd0;
        imem_ack      = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_req",  {31'd0, imem_req}, 32'd0);
        check("rst_pc",   pc, 32'h0);
        check("rst_fv",   {31'd0, fetch_valid}, 32'd0);
        check("rst_fpc",  fetch_pc, 32'h0);
        check("rst_pcp4", pc_plus4, 32'h4);
        rst_n = 1'b1;
        #1;
        check("boot_req", {31'd0, imem_req}, 32'd0);
        tick();
        check("t1_req0",  {31'd0, imem_req}, 32'd1);
        check("t1_addr0", imem_addr, 32'h0);

        // ---------------- 1: sequential fetches, ack every cycle ----------
        imem_ack = 1'b1;
        sb.push_back(32'h0);
        tick();
        check("t1_addr4", imem_addr, 32'h4);
        sb.push_back(32'h4);
        tick();
        check("t1_addr8", imem_addr, 32'h8);
        sb.push_back(32'h8);
        tick();
        check("t1_addrC", imem_addr, 32'hC);
        imem_ack = 1'b0;
        tick();
        check("t1_hold_addr", imem_addr, 32'hC);
        check("t1_hold_req",  {31'd0, imem_req}, 32'd1);

        // ---------------- 2: jump on ack cycle -----------------------------
        jr = 1'b1; jr_addr = 32'h4000_0013; imem_ack = 1'b1;
        tick();
        check("t2_jr_setup", imem_addr, 32'h4000_0010);
        clear_strobes();
        jump = 1'b1; jump_target = 26'h0100040;
        tick();  // dirty ack: tick confirms fetch_valid stays low
        check("t2_jump_addr", imem_addr, 32'h4040_0100);
        clear_strobes();

        // ---------------- 3: branch while ack held low 3 cycles -----------
        jr = 1'b1; jr_addr = 32'h0000_0100;
        tick();
        check("t3_setup", imem_addr, 32'h100);
        clear_strobes();
        imem_ack = 1'b0;
        branch_taken = 1'b1; branch_offset = 16'hFFFE;
        tick();
        check("t3_wait1", imem_addr, 32'h100);
        check("t3_wait1_req", {31'd0, imem_req}, 32'd1);
        clear_strobes();
        stall = 1'b1;  // stall without ack must not drop the request
        tick();
        check("t3_wait2", imem_addr, 32'h100);
        check("t3_wait2_req", {31'd0, imem_req}, 32'd1);
        stall = 1'b0;
        tick();
        check("t3_wait3", imem_addr, 32'h100);
        imem_ack = 1'b1;
        tick();  // pending redirect squashes this instruction
        check("t3_redir_addr", imem_addr, 32'h0FC);
        sb.push_back(32'h0FC);
        tick();
        check("t3_next_addr", imem_addr, 32'h100);

        // ---------------- 4: jr and jump together --------------------------
        jr = 1'b1; jr_addr = 32'h0000_2003;
        jump = 1'b1; jump_target = 26'h3FF_FFFF;
        branch_taken = 1'b1; branch_offset = 16'h0100;
        tick();
        check("t4_prio_addr", imem_addr, 32'h2000);
        clear_strobes();

        // ---------------- 5: stall on ack, branch in HOLD ------------------
        stall = 1'b1;
        sb.push_back(32'h2000);
        tick();
        check("t5_req_low", {31'd0, imem_req}, 32'd0);
        check("t5_pc",      pc, 32'h2004);
        imem_ack = 1'b0;
        branch_taken = 1'b1; branch_offset = 16'h0010;
        tick();
        check("t5_hold_pc",  pc, 32'h2048);
        check("t5_hold_req", {31'd0, imem_req}, 32'd0);
        clear_strobes();
        tick();
        check("t5_still_hold", {31'd0, imem_req}, 32'd0);
        stall = 1'b0;
        tick();
        check("t5_resume_req",  {31'd0, imem_req}, 32'd1);
        check("t5_resume_addr", imem_addr, 32'h2048);

        // ---------------- 6: wrap and async reset mid-fetch ----------------
        jr = 1'b1; jr_addr = 32'hFFFF_FFFC; imem_ack = 1'b1;
        tick();
        check("t6_setup", imem_addr, 32'hFFFF_FFFC);
        check("t6_pcp4_wrap", pc_plus4, 32'h0);
        clear_strobes();
        sb.push_back(32'hFFFF_FFFC);
        tick();
        check("t6_wrap_pc", pc, 32'h0);
        imem_ack = 1'b0;
        branch_taken = 1'b1; branch_offset = 16'h0010;
        tick();  // redirect parked as pending
        check("t6_pend_addr", imem_addr, 32'h0);
        clear_strobes();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_req", {31'd0, imem_req}, 32'd0);
        check("t6_async_pc",  pc, 32'h0);
        #1;
        rst_n = 1'b1;
        tick();
        check("t6_reboot_req",  {31'd0, imem_req}, 32'd1);
        check("t6_reboot_addr", imem_addr, 32'h0);
        imem_ack = 1'b1;
        sb.push_back(32'h0);  // pending redirect was lost, so this ack is clean
        tick();
        check("t6_after_addr", imem_addr, 32'h4);
        imem_ack = 1'b0;
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
